// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pipe_pkg                                                    |
// | Purpose: Shared pipeline definitions: ALUOp encodings understood by  |
// |          main control and ALU control, bit positions inside the      |
// |          7-bit decoded control word, and the NOP encodings written   |
// |          into EX on a bubble or flush.                               |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int CTRL_W  = 7;
  localparam int ALUOP_W = 4;
  localparam int REGS_W  = 15;
  localparam int FUNCT_W = 6;

  // Bit positions inside id_ctrl / ex_ctrl.
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_MEM_READ  = 4;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_ALU_SRC   = 1;
  localparam int CTRL_REG_DST   = 0;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 4'b0000,  // lw / sw / addi / addiu
    ALUOP_SUB   = 4'b0001,  // beq compare
    ALUOP_RTYPE = 4'b0010,  // decode via funct
    ALUOP_LUI   = 4'b0011,
    ALUOP_ORI   = 4'b0100
  } alu_op_e;

  // A NOP is an add with every side effect disabled (reg_write = 0).
  localparam logic [CTRL_W-1:0]  NOP_CTRL   = '0;
  localparam logic [ALUOP_W-1:0] NOP_ALU_OP = ALUOP_ADD;

  // A NOP is written on any non-frozen cycle that carries a kill request.
  function automatic logic nop_cycle(input logic hold, input logic flush,
                                     input logic bubble, input logic pending);
    return !hold && (flush || bubble || pending);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : id_ex_stage_reg_if                                          |
// | Purpose: Bundles the ID-side inputs, pipeline controls and EX-side   |
// |          outputs of the ID/EX register.                              |
// | Ports  : master - drives id_* and hold/bubble/flush, observes ex_*   |
// |          slave  - the stage register itself                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  import pipe_pkg::*;

  logic                hold;
  logic                bubble;
  logic                flush;

  logic                id_valid;
  logic [CTRL_W-1:0]   id_ctrl;
  logic [ALUOP_W-1:0]  id_alu_op;
  logic [DATA_W-1:0]   id_rs_data;
  logic [DATA_W-1:0]   id_rt_data;
  logic [DATA_W-1:0]   id_imm;
  logic [REGS_W-1:0]   id_regs;
  logic [FUNCT_W-1:0]  id_funct;
  logic [DATA_W-1:0]   id_pc4;

  logic                ex_valid;
  logic [CTRL_W-1:0]   ex_ctrl;
  logic [ALUOP_W-1:0]  ex_alu_op;
  logic [DATA_W-1:0]   ex_rs_data;
  logic [DATA_W-1:0]   ex_rt_data;
  logic [DATA_W-1:0]   ex_imm;
  logic [REGS_W-1:0]   ex_regs;
  logic [FUNCT_W-1:0]  ex_funct;
  logic [DATA_W-1:0]   ex_pc4;

  logic                flush_pending;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output hold, bubble, flush,
    output id_valid, id_ctrl, id_alu_op, id_rs_data, id_rt_data,
    output id_imm, id_regs, id_funct, id_pc4,
    input  ex_valid, ex_ctrl, ex_alu_op, ex_rs_data, ex_rt_data,
    input  ex_imm, ex_regs, ex_funct, ex_pc4,
    input  flush_pending, bubble_cnt
  );

  modport slave (
    input  hold, bubble, flush,
    input  id_valid, id_ctrl, id_alu_op, id_rs_data, id_rt_data,
    input  id_imm, id_regs, id_funct, id_pc4,
    output ex_valid, ex_ctrl, ex_alu_op, ex_rs_data, ex_rt_data,
    output ex_imm, ex_regs, ex_funct, ex_pc4,
    output flush_pending, bubble_cnt
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sat_counter                                                 |
// | Purpose: Up-counter that sticks at all-ones instead of wrapping.     |
// | Ports  : clk, rst (async, active-high), clear_i (sync clear),        |
// |          inc_i (count one), count_o (current value)                  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_i,
  input  wire logic             inc_i,
  output logic      [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : id_ex_stage_reg                                             |
// | Purpose: ID/EX pipeline register with hold, bubble and flush, a      |
// |          sticky flush remembered across hold, and a saturating       |
// |          count of NOPs written into EX.                              |
// | Ports  : clk, rst (async, active-high)                               |
// |          stage_if (slave) - id_* in, ex_* out, hold/bubble/flush,    |
// |                             flush_pending, bubble_cnt                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input wire logic          clk,
  input wire logic          rst,
  id_ex_stage_reg_if.slave  stage_if
);

  logic                valid_q,   valid_d;
  logic [CTRL_W-1:0]   ctrl_q,    ctrl_d;
  logic [ALUOP_W-1:0]  alu_op_q,  alu_op_d;
  logic [DATA_W-1:0]   rs_data_q, rs_data_d;
  logic [DATA_W-1:0]   rt_data_q, rt_data_d;
  logic [DATA_W-1:0]   imm_q,     imm_d;
  logic [REGS_W-1:0]   regs_q,    regs_d;
  logic [FUNCT_W-1:0]  funct_q,   funct_d;
  logic [DATA_W-1:0]   pc4_q,     pc4_d;
  logic                pending_q, pending_d;

  logic                nop_w;
  logic [CNT_W-1:0]    bubble_cnt_w;

  // One count per NOP cycle, however many kill sources are active.
  assign nop_w = nop_cycle(stage_if.hold, stage_if.flush,
                           stage_if.bubble, pending_q);

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    alu_op_d  = alu_op_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    regs_d    = regs_q;
    funct_d   = funct_q;
    pc4_d     = pc4_q;
    pending_d = pending_q;

    if (stage_if.hold) begin
      // Bubble is dropped here: the hazard unit re-raises it once the
      // stall clears. A flush cannot be dropped, so it is remembered.
      if (stage_if.flush) begin
        pending_d = 1'b1;
      end
    end else if (nop_w) begin
      valid_d   = 1'b0;
      ctrl_d    = NOP_CTRL;
      alu_op_d  = NOP_ALU_OP;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      regs_d    = '0;
      funct_d   = '0;
      pc4_d     = '0;
      pending_d = 1'b0;
    end else begin
      valid_d   = stage_if.id_valid;
      ctrl_d    = stage_if.id_ctrl;
      alu_op_d  = stage_if.id_alu_op;
      rs_data_d = stage_if.id_rs_data;
      rt_data_d = stage_if.id_rt_data;
      imm_d     = stage_if.id_imm;
      regs_d    = stage_if.id_regs;
      funct_d   = stage_if.id_funct;
      pc4_d     = stage_if.id_pc4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      regs_q    <= '0;
      funct_q   <= '0;
      pc4_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      regs_q    <= regs_d;
      funct_q   <= funct_d;
      pc4_q     <= pc4_d;
      pending_q <= pending_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (nop_w),
    .count_o (bubble_cnt_w)
  );

  assign stage_if.ex_valid      = valid_q;
  assign stage_if.ex_ctrl       = ctrl_q;
  assign stage_if.ex_alu_op     = alu_op_q;
  assign stage_if.ex_rs_data    = rs_data_q;
  assign stage_if.ex_rt_data    = rt_data_q;
  assign stage_if.ex_imm        = imm_q;
  assign stage_if.ex_regs       = regs_q;
  assign stage_if.ex_funct      = funct_q;
  assign stage_if.ex_pc4        = pc4_q;
  assign stage_if.flush_pending = pending_q;
  assign stage_if.bubble_cnt    = bubble_cnt_w;

endmodule
`default_nettype wire

// File: doc/id_ex_stage_reg.md
Name:
id_ex_stage_reg

Overview:
- ID/EX pipeline register of the multistage pipeline.
- Captures decoded control, register-file data, the immediate, register indices and funct from the decode stage.
- Presents them to the execute stage, including the ALUOp/funct pair consumed by ALU control.
- Implements hold (freeze), bubble (load-use NOP) and flush (branch kill), a sticky pending-flush, and a saturating bubble counter.

Parameters:
- DATA_W, 32, width of the data, immediate and PC+4 fields.
- CNT_W, 16, width of bubble_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- hold  in  1  freeze the register (downstream stall)
- bubble  in  1  write a NOP this cycle (load-use hazard)
- flush  in  1  kill the instruction entering EX (taken branch)
- id_valid  in  1  decode slot holds a real instruction
- id_ctrl  in  7  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst}
- id_alu_op  in  4  ALUOp: 0000 add (lw/sw/addi/addiu), 0001 beq sub, 0010 R-type, 0011 lui, 0100 ori
- id_rs_data  in  DATA_W  register-file read port 1
- id_rt_data  in  DATA_W  register-file read port 2
- id_imm  in  DATA_W  extended immediate
- id_regs  in  15  {rs, rt, rd}
- id_funct  in  6  instr[5:0]
- id_pc4  in  DATA_W  PC+4
- ex_valid, ex_ctrl, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_regs, ex_funct, ex_pc4  out  same widths as the id_* inputs  registered copies
- flush_pending  out  1  a flush seen under hold that has not yet been applied
- bubble_cnt  out  CNT_W  NOPs written into EX since reset, saturating

Behaviour:
- Reset (asynchronous): every ex_* output is 0, flush_pending is 0 and bubble_cnt is 0. This means ex_alu_op=0000 and ex_funct=000000, which decodes as a harmless add with reg_write=0.
- Each rising edge takes exactly one action, in this priority order:
  1. hold=1: all ex_* outputs keep their values. If flush=1, flush_pending is set. bubble is ignored because the hazard unit re-asserts it.
  2. flush=1, bubble=1 or flush_pending=1: a NOP is written. ex_valid, ex_ctrl, ex_alu_op, ex_funct, ex_regs, ex_rs_data, ex_rt_data, ex_imm and ex_pc4 are all set to 0. flush_pending is cleared. bubble_cnt increments.
  3. Otherwise: all id_* inputs are loaded, with ex_valid=id_valid.
- Latency is 1 cycle from ID to EX. There is no combinational path from input to output.
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap. Exactly one increment occurs per NOP cycle, even when flush and bubble are asserted together.
- flush_pending is sticky across any number of hold cycles. It is consumed by the first non-hold cycle, which writes the NOP.
- A load with id_valid=0 still copies the id_* fields but does not count as a bubble.
- An asynchronous rst asserted mid-hold or with a flush pending clears everything immediately. No pending flush survives reset.

Decomposition:
- Shared package pipe_pkg holds:
  - the ALUOp encodings listed above, shared with ALU control and main control;
  - the ID_CTRL bit indices;
  - the NOP constant for ctrl and alu_op.
- Natural sub-module: sat_counter (parameterised CNT_W, with inc and clear) for bubble_cnt.

Test Plan:
- Reset, then load lw (id_alu_op=0000, id_ctrl=7'b1110010, id_imm=4) → next cycle ex_alu_op=0000, ex_ctrl=7'b1110010, ex_imm=4, ex_valid=1, bubble_cnt=0.
- Load an R-type sub (alu_op=0010, funct=100010, regs={1,2,3}); assert hold for 3 cycles with changing id_* → ex_* stay frozen for those 3 cycles.
- Assert bubble for 1 cycle → ex_ctrl=0, ex_valid=0, ex_alu_op=0; bubble_cnt goes 0→1. Next cycle loads normally.
- Assert flush together with bubble → exactly one NOP is written and bubble_cnt increments by exactly 1.
- Assert flush during hold → flush_pending=1 while held. On the first cycle after hold drops, a NOP is written, flush_pending=0 and bubble_cnt increments.
- With CNT_W=2, issue 5 bubbles → bubble_cnt=3. Assert rst with flush_pending=1 → all outputs are 0 asynchronously, before the next clock edge.
